count_seq_monitor: RTL and testbench
====================================

COUNT_SEQ_MONITOR -- requirements
Module: count_seq_monitor

Interface
REQ-001 The block SHALL have parameter WRAP_W, default 8, giving the width of the wrap counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset of all state.
REQ-004 The block SHALL have port q_in, input, 2 bits: the count value from the upstream 2-bit counter, which changes on the clk falling edge.
REQ-005 The block SHALL have port cnt_rst, input, 1 bit: a copy of the upstream counter's reset; while high, the upstream output is forced to 0.
REQ-006 The block SHALL have port locked, output, 1 bit: high while the monitor is tracking a valid 0-1-2-3 sequence.
REQ-007 The block SHALL have port wrap_pulse, output, 1 bit: a one-cycle pulse on each observed 3->0 transition while locked.
REQ-008 The block SHALL have port wrap_count, output, WRAP_W bits: the number of wraps observed while locked.
REQ-009 The block SHALL have port seq_err, output, 1 bit: a one-cycle pulse on each sequence violation detected while locked.
REQ-010 The block SHALL have port err_count, output, 4 bits: a saturating count of seq_err pulses.

Function
REQ-011 The block SHALL sample q_in and cnt_rst on every clk rising edge and hold the previous sample in register prev (2 bits).
REQ-012 The block SHALL implement a 3-state FSM: IDLE, SYNC, LOCKED.
REQ-013 IDLE: entered on reset or while cnt_rst=1; it SHALL perform no sequence checks; when cnt_rst=0 it SHALL capture prev=q_in and go to SYNC.
REQ-014 SYNC: if q_in == prev+1 (mod 4), go to LOCKED; otherwise stay in SYNC; prev=q_in in both cases; no seq_err in SYNC.
REQ-015 LOCKED: if q_in == prev+1 (mod 4), stay; otherwise pulse seq_err, increment err_count, and go to SYNC; prev=q_in in both cases.
REQ-016 From any state, cnt_rst=1 at a rising edge SHALL force IDLE next cycle with no seq_err, no wrap_pulse, and no counter updates.
REQ-017 locked SHALL be 1 exactly in the cycles the FSM is in LOCKED (registered state decode).
REQ-018 wrap_pulse SHALL assert for one cycle when the FSM is in LOCKED, prev=3, and q_in=0; in that same edge wrap_count SHALL increment.
REQ-019 wrap_count SHALL wrap modulo 2^WRAP_W (all-ones -> 0) without an error.
REQ-020 err_count SHALL saturate at 15; further errors SHALL still pulse seq_err.
REQ-021 A violation in which q_in equals prev (stall) or jumps by 2 or 3 SHALL count as an error; a 3->0 step is legal.
REQ-022 seq_err and wrap_pulse SHALL never assert in the same cycle.
REQ-023 All outputs SHALL be registered; detection-to-output latency SHALL be 1 clk from the sampling edge.

Reset
REQ-024 When reset=1, asynchronously: state=IDLE, prev=0, locked=0, wrap_pulse=0, wrap_count=0, seq_err=0, err_count=0.
REQ-025 Reset asserted mid-operation SHALL clear all counts immediately, independent of clk; operation resumes on the first rising edge after deassertion.
REQ-026 cnt_rst SHALL NOT clear wrap_count or err_count; only reset does.

Verification
REQ-027 Reset, then q_in=0,1,2,3 on successive edges with cnt_rst=0 -> locked=1 from the cycle after the q_in=1 sample; seq_err never asserts.
REQ-028 Locked, feed 0,1,2,3 repeated 300 times -> 300 wrap_pulse cycles; wrap_count=300 mod 256=44 (WRAP_W=8).
REQ-029 Locked at prev=1, feed q_in=3 -> seq_err for 1 cycle, err_count=1, locked=0; then 0,1 -> locked=1 again.
REQ-030 Locked, inject 20 stall violations (q_in repeated) -> err_count=15, seq_err pulses 20 times.
REQ-031 Locked with wrap_count=5, err_count=2, assert cnt_rst for 3 cycles -> IDLE, locked=0, no seq_err, counts stay 5 and 2; resume the sequence -> relock.
REQ-032 Assert reset between clk edges while locked with wrap_count=7 -> all outputs are 0 before the next edge.

Source files
------------

// File: rtl/count_seq_monitor.sv
// Watches a free-running 2-bit counter, locks onto its 0-1-2-3 sequence and
// reports wraps and sequence violations with registered pulses and counters.
module count_seq_monitor #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        q_in,
    input  logic              cnt_rst,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              seq_err,
    output logic [3:0]        err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] prev;
    logic [1:0] prev_inc;
    logic       step_ok;
    logic       wrap_hit;
    logic       err_hit;

    assign prev_inc = prev + 2'd1;
    assign step_ok  = (q_in == prev_inc);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: default assignment first, so no path leaves next_state unassigned
    // and no latch is inferred.
    always_comb begin
        next_state = state;
        if (cnt_rst) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:    next_state = SYNC;
                SYNC:    next_state = step_ok ? LOCKED : SYNC;
                LOCKED:  next_state = step_ok ? LOCKED : SYNC;
                default: next_state = IDLE;
            endcase
        end
    end

    // A 3->0 step is itself a legal increment, so wraps and errors are exclusive.
    always_comb begin
        wrap_hit = 1'b0;
        err_hit  = 1'b0;
        if (!cnt_rst && state == LOCKED) begin
            wrap_hit = step_ok && (prev == 2'd3);
            err_hit  = !step_ok;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev       <= 2'd0;
            locked     <= 1'b0;
            wrap_pulse <= 1'b0;
            seq_err    <= 1'b0;
            wrap_count <= '0;
            err_count  <= 4'd0;
        end else begin
            locked     <= (next_state == LOCKED);
            wrap_pulse <= wrap_hit;
            seq_err    <= err_hit;
            if (!cnt_rst) begin
                prev <= q_in;
            end
            if (wrap_hit) begin
                wrap_count <= wrap_count + WRAP_W'(1);
            end
            if (err_hit && err_count != 4'hF) begin
                err_count <= err_count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Scoreboard bench for count_seq_monitor: stimulus pushes model expectations,
// a monitor pops and compares them one clock edge later.
module tb_count_seq_monitor;

    localparam int WRAP_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        q_in = 2'd0;
    logic              cnt_rst = 1'b0;
    logic              locked;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              seq_err;
    logic [3:0]        err_count;

    count_seq_monitor #(.WRAP_W(WRAP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .q_in       (q_in),
        .cnt_rst    (cnt_rst),
        .locked     (locked),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .seq_err    (seq_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              locked;
        logic              wrap_pulse;
        logic [WRAP_W-1:0] wrap_count;
        logic              seq_err;
        logic [3:0]        err_count;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   obs_wraps = 0;
    int   obs_errs  = 0;

    // Reference model: samples seen since the last counter reset, plus totals.
    int hist[$];
    int m_wraps = 0;
    int m_errs  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_wraps = 0;
        m_errs  = 0;
    endtask

    task automatic model_step(input int q, input bit cr, output exp_t e);
        bit was_locked;
        bit ok;
        bit wrap;
        bit err;
        was_locked = 1'b0;
        ok   = 1'b0;
        wrap = 1'b0;
        err  = 1'b0;
        if (cr) begin
            hist.delete();
        end else begin
            if (hist.size() >= 2)
                was_locked = (hist[hist.size()-1] == (hist[hist.size()-2] + 1) % 4);
            if (hist.size() >= 1) begin
                ok   = (q == (hist[hist.size()-1] + 1) % 4);
                wrap = was_locked && ok && (hist[hist.size()-1] == 3);
            end
            err = was_locked && !ok;
            hist.push_back(q);
            if (hist.size() > 2) void'(hist.pop_front());
        end
        if (wrap) m_wraps++;
        if (err)  m_errs++;
        e.locked     = ok;
        e.wrap_pulse = wrap;
        e.wrap_count = WRAP_W'(m_wraps % (1 << WRAP_W));
        e.seq_err    = err;
        e.err_count  = 4'((m_errs > 15) ? 15 : m_errs);
    endtask

    task automatic step(input int q, input bit cr);
        exp_t e;
        @(negedge clk);
        reset   = 1'b0;
        q_in    = 2'(q);
        cnt_rst = cr;
        model_step(q, cr, e);
        sb.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Asserts reset between edges and confirms outputs clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_locked",     32'(locked),     0);
        check("rst_wrap_pulse", 32'(wrap_pulse), 0);
        check("rst_wrap_count", 32'(wrap_count), 0);
        check("rst_seq_err",    32'(seq_err),    0);
        check("rst_err_count",  32'(err_count),  0);
    endtask

    // Monitor: compares the DUT against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("locked",     32'(locked),     32'(e.locked));
                check("wrap_pulse", 32'(wrap_pulse), 32'(e.wrap_pulse));
                check("wrap_count", 32'(wrap_count), 32'(e.wrap_count));
                check("seq_err",    32'(seq_err),    32'(e.seq_err));
                check("err_count",  32'(err_count),  32'(e.err_count));
                check("no_overlap", 32'(wrap_pulse & seq_err), 0);
                if (wrap_pulse) obs_wraps++;
                if (seq_err)    obs_errs++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        int last_q;

        // Lock-up from reset
        do_reset();
        obs_errs = 0;
        for (int i = 0; i < 4; i++) step(i, 1'b0);
        settle();
        check("lock_locked", 32'(locked), 1);
        check("lock_no_err", 32'(obs_errs), 0);

        // 300 full laps while locked
        obs_wraps = 0;
        repeat (300) for (int i = 0; i < 4; i++) step(i, 1'b0);
        settle();
        check("wrap_pulses_300", 32'(obs_wraps), 300);
        check("wrap_count_44",   32'(wrap_count), 44);

        // Jump 1->3 while locked, then relock
        step(0, 1'b0);
        step(1, 1'b0);
        step(3, 1'b0);
        settle();
        check("jump_seq_err",   32'(seq_err),   1);
        check("jump_err_count", 32'(err_count), 1);
        check("jump_unlocked",  32'(locked),    0);
        step(0, 1'b0);
        step(1, 1'b0);
        settle();
        check("jump_relocked", 32'(locked), 1);

        // 20 stalls, each from the locked state
        obs_errs = 0;
        cur = 1;
        for (int i = 0; i < 20; i++) begin
            step(cur, 1'b0);
            cur = (cur + 1) % 4;
            step(cur, 1'b0);
        end
        settle();
        check("stall_pulses", 32'(obs_errs),  20);
        check("stall_sat",    32'(err_count), 15);

        // Counter reset keeps counts and returns to idle
        do_reset();
        for (int i = 0; i < 4; i++) step(i, 1'b0);
        repeat (5) for (int i = 0; i < 4; i++) step(i, 1'b0);
        step(3, 1'b0);
        step(0, 1'b0);
        step(0, 1'b0);
        step(1, 1'b0);
        settle();
        check("pre_crst_wraps", 32'(wrap_count), 5);
        check("pre_crst_errs",  32'(err_count),  2);
        obs_errs = 0;
        obs_wraps = 0;
        repeat (3) step(0, 1'b1);
        settle();
        check("crst_unlocked", 32'(locked),     0);
        check("crst_wraps",    32'(wrap_count), 5);
        check("crst_errs",     32'(err_count),  2);
        check("crst_no_err",   32'(obs_errs),   0);
        check("crst_no_wrap",  32'(obs_wraps),  0);
        step(0, 1'b0);
        step(1, 1'b0);
        step(2, 1'b0);
        settle();
        check("crst_relocked", 32'(locked), 1);

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 4; i++) step(i, 1'b0);
        repeat (7) for (int i = 0; i < 4; i++) step(i, 1'b0);
        settle();
        check("pre_async_wraps", 32'(wrap_count), 7);
        check("pre_async_lock",  32'(locked),     1);
        do_reset();

        // Randomized traffic, mostly legal increments
        last_q = 0;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 39) == 0) begin
                last_q = 0;
                step(0, 1'b1);
            end else begin
                if ($urandom_range(0, 9) < 8) last_q = (last_q + 1) % 4;
                else                          last_q = int'($urandom_range(0, 3));
                step(last_q, 1'b0);
            end
        end
        settle();
        check("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
